alarm_clock_ctrl: RTL and testbench



---
 rtl/alarm_clock_ctrl_pkg.sv | 17 +
 rtl/alarm_clock_ctrl_wrap_inc.sv | 12 +
 rtl/alarm_clock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_ctrl_pkg.sv
// Shared definitions for the alarm-clock mode controller: mode encodings,
// mode-bus width and default field limits.
package alarm_clock_ctrl_pkg;

  localparam int MODE_W      = 3;
  localparam int DEF_HR_MAX  = 23;
  localparam int DEF_MIN_MAX = 59;

  typedef enum logic [MODE_W-1:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_e;

endpackage

// File: rtl/alarm_clock_ctrl_wrap_inc.sv
// Increment-with-wrap: returns i_val + 1, or 0 once i_val has reached i_max.
module wrap_inc #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_val
);

  assign o_val = (i_val >= i_max) ? '0 : i_val + W'(1);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm-clock mode/sequencing controller. Steps through editing time and
// alarm fields from two button pulses, strobes loads into the time chain,
// gates its count enable while editing and raises the alarm ring.
// Optional snooze timer built when ALARM_SNOOZE_EN is defined.
module alarm_clock_ctrl
  import alarm_clock_ctrl_pkg::*;
#(
  parameter int HR_BITS      = 5,
  parameter int MIN_BITS     = 6,
  parameter int HR_MAX       = DEF_HR_MAX,
  parameter int MIN_MAX      = DEF_MIN_MAX,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                btn_mode,
  input  logic                btn_inc,
  input  logic [HR_BITS-1:0]  cur_hr,
  input  logic [MIN_BITS-1:0] cur_min,
  output logic                run_en,
  output logic                set_hr,
  output logic                set_min,
  output logic [HR_BITS-1:0]  set_val_hr,
  output logic [MIN_BITS-1:0] set_val_min,
  output logic [HR_BITS-1:0]  alm_hr,
  output logic [MIN_BITS-1:0] alm_min,
  output logic [MODE_W-1:0]   mode,
  output logic                ringing
);

  // One edit register serves both hour and minute edits.
  localparam int EDIT_W = (HR_BITS > MIN_BITS) ? HR_BITS : MIN_BITS;

  mode_e               r_mode;
  logic                r_run_en;
  logic                r_set_hr;
  logic                r_set_min;
  logic [HR_BITS-1:0]  r_set_val_hr;
  logic [MIN_BITS-1:0] r_set_val_min;
  logic [HR_BITS-1:0]  r_alm_hr;
  logic [MIN_BITS-1:0] r_alm_min;
  logic [EDIT_W-1:0]   r_edit;
  logic                r_ringing;
  logic                r_fired;

  logic [EDIT_W-1:0]   w_edit_max;
  logic [EDIT_W-1:0]   w_edit_inc;
  logic [HR_BITS-1:0]  w_alm_hr_inc;
  logic [MIN_BITS-1:0] w_alm_min_inc;
  logic                w_time_eq;
  logic                w_match;

  assign w_edit_max = (r_mode == SET_HR) ? EDIT_W'(HR_MAX) : EDIT_W'(MIN_MAX);
  assign w_time_eq  = (cur_hr == r_alm_hr) && (cur_min == r_alm_min);
  assign w_match    = (r_mode == RUN) && w_time_eq && !r_fired;

  wrap_inc #(.W(EDIT_W)) u_edit_inc (
    .i_val (r_edit),
    .i_max (w_edit_max),
    .o_val (w_edit_inc)
  );

  wrap_inc #(.W(HR_BITS)) u_alm_hr_inc (
    .i_val (r_alm_hr),
    .i_max (HR_BITS'(HR_MAX)),
    .o_val (w_alm_hr_inc)
  );

  wrap_inc #(.W(MIN_BITS)) u_alm_min_inc (
    .i_val (r_alm_min),
    .i_max (MIN_BITS'(MIN_MAX)),
    .o_val (w_alm_min_inc)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);
  logic             r_snz_act;
  logic [SNZ_W-1:0] r_snz_cnt;
  logic             w_snz_due;
  assign w_snz_due = r_snz_act && (r_snz_cnt == '0) && (r_mode == RUN);
`else
  // tick only paces the snooze timer, which this build does not have
  logic w_unused_tick;
  assign w_unused_tick = tick;
`endif

  // Mode FSM with edit/alarm registers, load strobes and ring control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode        <= RUN;
      r_run_en      <= 1'b1;
      r_set_hr      <= 1'b0;
      r_set_min     <= 1'b0;
      r_set_val_hr  <= '0;
      r_set_val_min <= '0;
      r_alm_hr      <= '0;
      r_alm_min     <= '0;
      r_edit        <= '0;
      r_ringing     <= 1'b0;
      r_fired       <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz_act     <= 1'b0;
      r_snz_cnt     <= '0;
`endif
    end else begin
      r_set_hr  <= 1'b0;
      r_set_min <= 1'b0;
      // Re-arm once the live time has moved off the alarm minute.
      if (!w_time_eq) r_fired <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      if (r_snz_act && tick && (r_snz_cnt != '0)) r_snz_cnt <= r_snz_cnt - SNZ_W'(1);
`endif
      if (r_ringing) begin
        // Buttons are consumed by the alarm; mode never changes here.
        if (btn_mode) begin
          r_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          r_snz_act <= 1'b0;
`endif
        end else if (btn_inc) begin
          r_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          r_snz_act <= 1'b1;
          r_snz_cnt <= SNZ_W'(SNOOZE_TICKS);
`endif
        end
      end else if (w_match) begin
        r_ringing <= 1'b1;
        r_fired   <= 1'b1;
`ifdef ALARM_SNOOZE_EN
      end else if (w_snz_due) begin
        r_ringing <= 1'b1;
        r_snz_act <= 1'b0;
`endif
      end else begin
        case (r_mode)
          RUN: begin
            if (btn_mode) begin
              r_mode   <= SET_HR;
              r_run_en <= 1'b0;
              r_edit   <= EDIT_W'(cur_hr);
`ifdef ALARM_SNOOZE_EN
              r_snz_act <= 1'b0;
`endif
            end
          end
          SET_HR: begin
            if (btn_mode) begin
              r_mode       <= SET_MIN;
              r_set_hr     <= 1'b1;
              r_set_val_hr <= HR_BITS'(r_edit);
              r_edit       <= EDIT_W'(cur_min);
            end else if (btn_inc) begin
              r_edit <= w_edit_inc;
            end
          end
          SET_MIN: begin
            if (btn_mode) begin
              r_mode        <= SET_AHR;
              r_run_en      <= 1'b1;
              r_set_min     <= 1'b1;
              r_set_val_min <= MIN_BITS'(r_edit);
            end else if (btn_inc) begin
              r_edit <= w_edit_inc;
            end
          end
          SET_AHR: begin
            if (btn_mode)     r_mode   <= SET_AMIN;
            else if (btn_inc) r_alm_hr <= w_alm_hr_inc;
          end
          SET_AMIN: begin
            if (btn_mode)     r_mode    <= RUN;
            else if (btn_inc) r_alm_min <= w_alm_min_inc;
          end
          default: begin
            r_mode   <= RUN;
            r_run_en <= 1'b1;
          end
        endcase
      end
    end
  end

  assign run_en      = r_run_en;
  assign set_hr      = r_set_hr;
  assign set_min     = r_set_min;
  assign set_val_hr  = r_set_val_hr;
  assign set_val_min = r_set_val_min;
  assign alm_hr      = r_alm_hr;
  assign alm_min     = r_alm_min;
  assign mode        = r_mode;
  assign ringing     = r_ringing;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Testbench for alarm_clock_ctrl: directed scenarios followed by random
// button/time traffic, all checked against a behavioural model.
// Snooze scenarios are compiled in when ALARM_SNOOZE_EN is defined.
module tb_alarm_clock_ctrl;

  localparam int SNZ = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, bm, bi;
  logic [4:0] hr;
  logic [5:0] mn;
  logic       run_en, set_hr, set_min, ringing;
  logic [4:0] set_val_hr, alm_hr;
  logic [5:0] set_val_min, alm_min;
  logic [2:0] mode;

  alarm_clock_ctrl #(.SNOOZE_TICKS(SNZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_mode    (bm),
    .btn_inc     (bi),
    .cur_hr      (hr),
    .cur_min     (mn),
    .run_en      (run_en),
    .set_hr      (set_hr),
    .set_min     (set_min),
    .set_val_hr  (set_val_hr),
    .set_val_min (set_val_min),
    .alm_hr      (alm_hr),
    .alm_min     (alm_min),
    .mode        (mode),
    .ringing     (ringing)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_mode, m_edit, m_ahr, m_amin, m_vhr, m_vmin, m_cnt;
  bit m_ring, m_fired, m_shr, m_smin, m_act;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_edit = 0; m_ahr = 0; m_amin = 0; m_vhr = 0; m_vmin = 0;
    m_ring = 0; m_fired = 0; m_shr = 0; m_smin = 0; m_act = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_step();
    bit eq, due;
    eq  = (int'(hr) == m_ahr) && (int'(mn) == m_amin);
    due = 0;
    m_shr = 0; m_smin = 0;
    if (!eq) m_fired = 0;
`ifdef ALARM_SNOOZE_EN
    due = m_act && (m_cnt == 0) && (m_mode == 0);
    if (m_act && tick && m_cnt != 0) m_cnt--;
`endif
    if (m_ring) begin
      if (bm) begin
        m_ring = 0; m_act = 0;
      end else if (bi) begin
        m_ring = 0;
`ifdef ALARM_SNOOZE_EN
        m_act = 1; m_cnt = SNZ;
`endif
      end
    end else if (m_mode == 0 && eq && !m_fired) begin
      m_ring = 1; m_fired = 1;
    end else if (due) begin
      m_ring = 1; m_act = 0;
    end else if (bm) begin
      if (m_mode == 1) begin m_shr = 1; m_vhr = m_edit; end
      if (m_mode == 2) begin m_smin = 1; m_vmin = m_edit; end
      m_mode = (m_mode + 1) % 5;
      if (m_mode == 1) begin m_edit = int'(hr); m_act = 0; end
      if (m_mode == 2) m_edit = int'(mn);
    end else if (bi) begin
      case (m_mode)
        1: m_edit = (m_edit + 1) % 24;
        2: m_edit = (m_edit + 1) % 60;
        3: m_ahr  = (m_ahr + 1) % 24;
        4: m_amin = (m_amin + 1) % 60;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("mode",        mode,        m_mode);
    check("run_en",      run_en,      (m_mode == 1 || m_mode == 2) ? 0 : 1);
    check("set_hr",      set_hr,      m_shr);
    check("set_min",     set_min,     m_smin);
    check("set_val_hr",  set_val_hr,  m_vhr);
    check("set_val_min", set_val_min, m_vmin);
    check("alm_hr",      alm_hr,      m_ahr);
    check("alm_min",     alm_min,     m_amin);
    check("ringing",     ringing,     m_ring);
  endtask

  // One clock: drive inputs, step model, sample after the edge.
  task automatic cyc(input bit t, input bit b_mode, input bit b_inc);
    tick = t; bm = b_mode; bi = b_inc;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    tick = 0; bm = 0; bi = 0;
  endtask

  // Asynchronous reset asserted between edges, released after one edge.
  task automatic do_reset();
    tick = 0; bm = 0; bi = 0;
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
  endtask

  initial begin
    rst = 0; tick = 0; bm = 0; bi = 0; hr = 5'd12; mn = 6'd0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check("reset_mode", mode, 0);
    check("reset_run_en", run_en, 1);

    // Idle in RUN
    for (int i = 0; i < 100; i++) cyc(($urandom % 4) == 0, 0, 0);

    // Hour edit with wrap 23 -> 0
    hr = 5'd22;
    cyc(0, 1, 0);
    check("enter_set_hr_run_en", run_en, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    mn = 6'd58;
    cyc(0, 1, 0);
    check("set_hr_pulse", set_hr, 1);
    check("set_val_hr_wrap", set_val_hr, 1);
    cyc(0, 0, 0);
    check("set_hr_one_cycle", set_hr, 0);

    // Minute edit with wrap 59 -> 0
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    check("set_min_pulse", set_min, 1);
    check("set_val_min_wrap", set_val_min, 0);
    check("mode_set_ahr", mode, 3);

    // Alarm 07:30
    hr = 5'd12; mn = 6'd0;
    for (int i = 0; i < 7; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    check("alm_hr_set", alm_hr, 7);
    check("alm_min_set", alm_min, 30);
    check("back_to_run", mode, 0);

    // Ring, dismiss, no re-ring in same minute, re-ring after leaving it
    hr = 5'd7; mn = 6'd30;
    cyc(0, 0, 0);
    check("ring_on_match", ringing, 1);
    cyc(0, 1, 0);
    check("dismiss_ring", ringing, 0);
    check("dismiss_keeps_run", mode, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    check("no_rering_same_min", ringing, 0);
    mn = 6'd31; cyc(0, 0, 0);
    mn = 6'd30; cyc(0, 0, 0);
    check("rering_after_change", ringing, 1);
    cyc(0, 0, 1);
    check("inc_dismiss", ringing, 0);
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < SNZ; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("snooze_rering", ringing, 1);
    cyc(0, 1, 0);
    check("snooze_mode_dismiss", ringing, 0);
    mn = 6'd31; cyc(0, 0, 0);
    mn = 6'd30; cyc(0, 0, 0);
    check("ring_before_snooze2", ringing, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    do_reset();
    for (int i = 0; i < 2 * SNZ + 2; i++) cyc(1, 0, 0);
    check("reset_cancels_snooze", ringing, 0);
`endif

    // Simultaneous buttons in SET_HR: mode wins, edit untouched
    do_reset();
    hr = 5'd5; mn = 6'd10;
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    check("both_btn_set_hr", set_hr, 1);
    check("both_btn_val", set_val_hr, 7);
    check("both_btn_mode", mode, 2);

    // Reset in the middle of an edit: no strobe, back to RUN
    cyc(0, 0, 1);
    do_reset();
    check("abort_no_strobe", set_min, 0);
    check("abort_mode", mode, 0);
    check("abort_val_min", set_val_min, 0);
    cyc(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 8) == 0) begin
        if ($urandom % 2) begin
          hr = 5'(m_ahr); mn = 6'(m_amin);
        end else begin
          hr = 5'($urandom_range(23, 0)); mn = 6'($urandom_range(59, 0));
        end
      end
      if (($urandom % 600) == 0) do_reset();
      else cyc(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
